// File: rtl/lpf_pkg.sv
// Shared constants for the biquad low-pass filter controller: widths,
// coefficient slot indices, coefficient reset values and FSM state encoding.
package lpf_pkg;
  localparam int DW    = 32;
  localparam int NCOEF = 6;

  localparam logic [2:0] CI_B0 = 3'd0;
  localparam logic [2:0] CI_B1 = 3'd1;
  localparam logic [2:0] CI_B2 = 3'd2;
  localparam logic [2:0] CI_A0 = 3'd3;
  localparam logic [2:0] CI_A1 = 3'd4;
  localparam logic [2:0] CI_A2 = 3'd5;

  // Slot [0] is the least significant word, so flt_coef reads {a2,a1,a0,b2,b1,b0}
  typedef logic [NCOEF-1:0][DW-1:0] coef_vec_t;

  localparam coef_vec_t COEF_RST = {32'd27, 32'hFFFF_FFB6, 32'd1,
                                    32'd13, 32'd26, 32'd13};

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_WAIT   = 3'd1;
  localparam logic [2:0] ST_OUT    = 3'd2;
  localparam logic [2:0] ST_COMMIT = 3'd3;
  localparam logic [2:0] ST_FLUSH  = 3'd4;
  localparam logic [2:0] ST_DRAIN  = 3'd5;
endpackage

// File: rtl/lpf_coef_bank.sv
// Shadow/active coefficient registers. Writes only touch the shadow copy;
// the active copy changes solely on a commit strobe.
module lpf_coef_bank
  import lpf_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [2:0]    sel,
  input  logic [DW-1:0] wdata,
  input  logic          commit,
  output coef_vec_t     coef
);

  coef_vec_t shadow_q, shadow_d;
  coef_vec_t active_q, active_d;

  always_comb begin
    shadow_d = shadow_q;
    if (we && (sel <= CI_A2)) shadow_d[sel] = wdata;
    // Copy from shadow_d so a write in the commit cycle is not lost
    active_d = commit ? shadow_d : active_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= COEF_RST;
      active_q <= COEF_RST;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  assign coef = active_q;

endmodule

// File: rtl/lpf_ctrl.sv
// Sample sequencer and coefficient-commit controller for an external filter.
// Define LPF_CTRL_FLUSH_EN to zero-flush and drain the filter after each commit.
module lpf_ctrl
  import lpf_pkg::*;
#(
  parameter int FILT_LAT  = 2,
  parameter int FLUSH_LEN = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [DW-1:0]       s_data,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [DW-1:0]       m_data,
  input  logic                cfg_we,
  input  logic [2:0]          cfg_sel,
  input  logic [DW-1:0]       cfg_wdata,
  input  logic                cfg_commit,
  output logic                cfg_busy,
  output logic [DW-1:0]       flt_data,
  output logic                flt_en,
  output logic [NCOEF*DW-1:0] flt_coef,
  input  logic [DW-1:0]       flt_out
);

  logic [2:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          pend_q, pend_d;
  logic          m_valid_q, m_valid_d;
  logic [DW-1:0] m_data_q, m_data_d;
  logic [DW-1:0] flt_data_q, flt_data_d;
  logic          flt_en_q, flt_en_d;
  logic          pend_now;
  coef_vec_t     coef;

  // A commit arriving this cycle already blocks input, so it wins over s_valid
  assign pend_now = pend_q | cfg_commit;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pend_d     = pend_now;
    m_valid_d  = m_valid_q;
    m_data_d   = m_data_q;
    flt_data_d = flt_data_q;
    flt_en_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pend_now) begin
          state_d = ST_COMMIT;
        end else if (s_valid) begin
          flt_data_d = s_data;
          flt_en_d   = 1'b1;
          cnt_d      = 4'(FILT_LAT);
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          m_data_d  = flt_out;
          m_valid_d = 1'b1;
          state_d   = ST_OUT;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_OUT: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      ST_COMMIT: begin
        pend_d = cfg_commit;
`ifdef LPF_CTRL_FLUSH_EN
        flt_data_d = '0;
        flt_en_d   = 1'b1;
        cnt_d      = 4'(FLUSH_LEN - 1);
        state_d    = ST_FLUSH;
`else
        state_d = ST_IDLE;
`endif
      end
      ST_FLUSH: begin
        if (cnt_q == 4'd0) begin
          cnt_d   = 4'(FILT_LAT - 1);
          state_d = ST_DRAIN;
        end else begin
          cnt_d    = cnt_q - 4'd1;
          flt_en_d = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (cnt_q == 4'd0) state_d = ST_IDLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      flt_data_q <= '0;
      flt_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      flt_data_q <= flt_data_d;
      flt_en_q   <= flt_en_d;
    end
  end

  lpf_coef_bank u_coef_bank (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (cfg_we),
    .sel    (cfg_sel),
    .wdata  (cfg_wdata),
    .commit (state_q == ST_COMMIT),
    .coef   (coef)
  );

  assign s_ready  = rst_n && (state_q == ST_IDLE) && !pend_now;
  assign m_valid  = m_valid_q;
  assign m_data   = m_data_q;
  assign flt_data = flt_data_q;
  assign flt_en   = flt_en_q;
  assign flt_coef = coef;
  assign cfg_busy = pend_q || (state_q == ST_COMMIT) ||
                    (state_q == ST_FLUSH) || (state_q == ST_DRAIN);

endmodule

// File: tb/tb_lpf_ctrl.sv
// Directed bench for lpf_ctrl with a toy filter model: flt_out takes
// flt_data ^ 32'h5A5A0000 on each flt_en strobe.
module tb_lpf_ctrl;

  localparam logic [191:0] RST_COEF = {32'd27, 32'hFFFF_FFB6, 32'd1,
                                       32'd13, 32'd26, 32'd13};
  localparam logic [191:0] NEW_COEF = {32'd27, 32'hFFFF_FFBA, 32'd1,
                                       32'd13, 32'd26, 32'd13};

  logic         clk = 1'b0;
  logic         rst_n;
  logic         s_valid, s_ready, m_valid, m_ready;
  logic [31:0]  s_data, m_data;
  logic         cfg_we, cfg_commit, cfg_busy;
  logic [2:0]   cfg_sel;
  logic [31:0]  cfg_wdata, flt_data, flt_out;
  logic         flt_en;
  logic [191:0] flt_coef;

  int errs   = 0;
  int checks = 0;
  int en_cnt = 0;
  int e0;
  int n;

  lpf_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_wdata(cfg_wdata),
    .cfg_commit(cfg_commit), .cfg_busy(cfg_busy),
    .flt_data(flt_data), .flt_en(flt_en), .flt_coef(flt_coef),
    .flt_out(flt_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n)
    if (!rst_n)      flt_out <= '0;
    else if (flt_en) flt_out <= flt_data ^ 32'h5A5A_0000;

  always @(posedge clk) if (flt_en) en_cnt <= en_cnt + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [31:0] d);
    int k = 0;
    s_valid = 1'b1;
    s_data  = d;
    while (!s_ready && k < 40) begin step(); k++; end
    chk("accept_ready", s_ready, 1);
    step();
    s_valid = 1'b0;
    chk("flt_en_pulse", flt_en, 1);
    chk("flt_data", flt_data, d);
  endtask

  task automatic finish(input logic [31:0] exp, input int hold, input int lat);
    int k = 0;
    logic [31:0] held;
    while (!m_valid && k < 40) begin step(); k++; end
    chk("latency", k, lat);
    chk("m_data", m_data, exp);
    held = m_data;
    for (int i = 0; i < hold; i++) begin
      step();
      chk("hold_valid", m_valid, 1);
      chk("hold_data", m_data, held);
      chk("hold_sready", s_ready, 0);
    end
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    chk("m_valid_drop", m_valid, 0);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (cfg_busy && k < 40) begin step(); k++; end
    chk("busy_clear", cfg_busy, 0);
  endtask

  initial begin
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    cfg_we = 1'b0; cfg_sel = '0; cfg_wdata = '0; cfg_commit = 1'b0;
    #12;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_flt_en", flt_en, 0);
    chk("rst_flt_data", flt_data, 0);
    chk("rst_busy", cfg_busy, 0);
    chk("rst_coef", flt_coef, RST_COEF);
    @(negedge clk) rst_n = 1'b1;
    step();

    // Single sample
    e0 = en_cnt;
    accept(32'd10000);
    finish(32'h5A5A_2710, 0, 3);
    chk("single_coef", flt_coef, RST_COEF);
    chk("single_en_cnt", en_cnt - e0, 1);

    // Stream with backpressure on the first output
    e0 = en_cnt;
    accept(32'd10000);
    s_valid = 1'b1;
    s_data  = 32'd20000;
    finish(32'h5A5A_2710, 5, 3);
    accept(32'd20000);
    finish(32'h5A5A_4E20, 0, 3);
    accept(32'd24000);
    finish(32'h5A5A_5DC0, 0, 3);
    chk("stream_en_cnt", en_cnt - e0, 3);

    // Writes to unused slots are dropped
    cfg_we = 1'b1; cfg_sel = 3'd7; cfg_wdata = 32'hDEAD_BEEF;
    step();
    cfg_sel = 3'd6;
    step();
    cfg_we = 1'b0; cfg_commit = 1'b1;
    step();
    cfg_commit = 1'b0;
    chk("bad_sel_busy", cfg_busy, 1);
    wait_idle();
    chk("bad_sel_coef", flt_coef, RST_COEF);

    // Commit requested mid-sample is deferred to the sample boundary
    accept(32'd20000);
    cfg_we = 1'b1; cfg_sel = 3'd4; cfg_wdata = 32'hFFFF_FFBA;
    step();
    cfg_we = 1'b0; cfg_commit = 1'b1;
    step();
    cfg_commit = 1'b0;
    chk("defer_busy", cfg_busy, 1);
    chk("defer_coef_wait", flt_coef, RST_COEF);
    finish(32'h5A5A_4E20, 2, 1);
    chk("defer_coef_idle", flt_coef, RST_COEF);
    chk("defer_busy_idle", cfg_busy, 1);
    step();
    chk("defer_coef_commit", flt_coef, RST_COEF);
    step();
    chk("defer_a1", flt_coef[159:128], 32'hFFFF_FFBA);
    chk("defer_coef_new", flt_coef, NEW_COEF);
    wait_idle();

    // Commit and sample in the same idle cycle
    cfg_commit = 1'b1; s_valid = 1'b1; s_data = 32'd24000;
    #1;
    chk("prio_sready", s_ready, 0);
    step();
    cfg_commit = 1'b0;
    chk("prio_busy", cfg_busy, 1);
    e0 = en_cnt;
    n = 0;
    while (!s_ready && n < 40) begin step(); n++; end
`ifdef LPF_CTRL_FLUSH_EN
    chk("prio_wait", n, 7);
    chk("prio_flush_pulses", en_cnt - e0, 4);
    chk("prio_flush_data", flt_data, 0);
`else
    chk("prio_wait", n, 1);
    chk("prio_flush_pulses", en_cnt - e0, 0);
`endif
    chk("prio_coef", flt_coef, NEW_COEF);
    accept(32'd24000);
    finish(32'h5A5A_5DC0, 0, 3);

    // Reset while an output is waiting, with a commit pending
    accept(32'd10000);
    n = 0;
    while (!m_valid && n < 40) begin step(); n++; end
    cfg_commit = 1'b1;
    step();
    cfg_commit = 1'b0;
    chk("out_busy", cfg_busy, 1);
    chk("out_valid", m_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", m_valid, 0);
    chk("mid_rst_busy", cfg_busy, 0);
    chk("mid_rst_sready", s_ready, 0);
    chk("mid_rst_coef", flt_coef, RST_COEF);
    @(negedge clk) rst_n = 1'b1;
    step();
    chk("post_rst_busy", cfg_busy, 0);
    e0 = en_cnt;
    accept(32'd20000);
    finish(32'h5A5A_4E20, 0, 3);
    chk("post_rst_en_cnt", en_cnt - e0, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/lpf_ctrl.md
LPF_CTRL -- requirements
Module: lpf_ctrl

Interface
REQ-001 Parameter FILT_LAT, default 2: cycles from flt_en high to valid flt_out, range 1..15.
REQ-002 Parameter FLUSH_LEN, default 4: zero samples fed on coefficient commit, range 1..15.
REQ-003 clk  input  1  single clock; all logic rising-edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 s_valid / s_ready / s_data  in / out / in  1/1/32  input sample stream, valid/ready.
REQ-006 m_valid / m_ready / m_data  out / in / out  1/1/32  filtered output stream, valid/ready.
REQ-007 cfg_we / cfg_sel / cfg_wdata  in / in / in  1/3/32  shadow coefficient write; sel 0..5 = b0,b1,b2,a0,a1,a2.
REQ-008 cfg_commit  input  1  one-cycle pulse requesting shadow-to-active copy.
REQ-009 cfg_busy  output  1  commit pending or flush in progress.
REQ-010 flt_data  output  32  sample to filter.
REQ-011 flt_en  output  1  one-cycle advance strobe to filter.
REQ-012 flt_coef  output  192  active coefficients {a2,a1,a0,b2,b1,b0}, 32 bits each.
REQ-013 flt_out  input  32  filter result.

Function
REQ-014 FSM states: IDLE, WAIT, OUT, COMMIT, FLUSH, DRAIN.
REQ-015 IDLE: s_ready=1 iff no commit pending; on s_valid&&s_ready, latch s_data to flt_data, flt_en=1 for exactly one cycle, load counter=FILT_LAT, go WAIT.
REQ-016 WAIT: decrement counter each cycle; at 0 capture flt_out into m_data, set m_valid, go OUT; latency s accept -> m_valid = FILT_LAT+1 cycles.
REQ-017 OUT: m_valid and m_data held stable until m_ready; s_ready=0 (backpressure stalls input); on m_ready go IDLE.
REQ-018 cfg_commit sets commit_pend; repeated pulses while pending are absorbed (single commit).
REQ-019 Commit is applied only in IDLE (sample boundary): IDLE with commit_pend -> COMMIT; commit has priority over s_valid in the same cycle.
REQ-020 COMMIT: copy all six shadow registers to active in one cycle, clear commit_pend.
REQ-021 cfg_we in the same cycle as cfg_commit: written value lands in shadow before the copy.
REQ-022 cfg_we is accepted in every state; it never alters flt_coef directly.
REQ-023 cfg_sel 6 or 7: write ignored.
REQ-024 FLUSH: flt_data=0, flt_en=1 for FLUSH_LEN consecutive cycles; no m_valid.
REQ-025 DRAIN: wait FILT_LAT cycles, flt_out ignored, then IDLE.
REQ-026 cfg_busy=1 from cfg_commit cycle+1 until return to IDLE.
REQ-027 Coefficients are two's-complement 32-bit, passed unmodified; no arithmetic in this block.

Reset
REQ-028 rst_n low, asynchronous: state IDLE, counters 0, commit_pend=0, s_ready=0 while asserted, m_valid=0, m_data=0, flt_data=0, flt_en=0, cfg_busy=0.
REQ-029 Shadow and active coefficients reset to b0=13, b1=26, b2=13, a0=1, a1=-74, a2=27.
REQ-030 Reset mid-operation: in-flight sample and pending commit discarded, no m_valid produced.

Configuration
REQ-031 Macro LPF_CTRL_FLUSH_EN defined: COMMIT -> FLUSH -> DRAIN -> IDLE per REQ-024/025.
REQ-032 Macro absent: COMMIT -> IDLE directly; FLUSH and DRAIN unreachable, filter history retained across commits.

Structure
REQ-033 Package lpf_pkg holds data width 32, coefficient index constants (B0..A2), coefficient reset values, state enum.
REQ-034 Sub-module lpf_coef_bank holds shadow/active registers, write decode and commit copy.

Verification
REQ-035 Reset then s_data=10000 with m_ready=1 -> flt_en one pulse, m_valid 3 cycles later, m_data = flt_out at capture, flt_coef = reset values.
REQ-036 Stream 10000, 20000, 24000 with m_ready=0 for 5 cycles on first -> m_data held, s_ready=0, no sample lost or duplicated.
REQ-037 Write a1=-70 then cfg_commit while sample in WAIT -> flt_coef unchanged until that sample leaves OUT, then a1 field = -70.
REQ-038 cfg_commit and s_valid same cycle in IDLE -> commit first; with LPF_CTRL_FLUSH_EN, 4 zero flt_en pulses, 2 drain cycles, then sample accepted; without, sample accepted one cycle after COMMIT.
REQ-039 cfg_sel=7 write 0xDEADBEEF then commit -> flt_coef equals reset values.
REQ-040 rst_n low during OUT -> m_valid=0 immediately, cfg_busy=0, next sample processed normally after release.
